// File: rtl/evict_wb_buffer.sv
// Eviction write buffer: queues dirty L2 lines, drains them to memory one at a time, and serves lookups.
// Optional write coalescing is enabled by defining EWB_COALESCE_EN.
module evict_wb_buffer #(
   parameter int WIDTH  = 256,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   parameter int OFFSET = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enq_valid_i,
   input  logic [ADDR_W-1:0]         enq_addr_i,
   input  logic [WIDTH-1:0]          enq_data_i,
   output logic                      enq_ready_o,
   input  logic                      lkp_valid_i,
   input  logic [ADDR_W-1:0]         lkp_addr_i,
   output logic                      lkp_hit_o,
   output logic [WIDTH-1:0]          lkp_data_o,
   input  logic                      upd_i,
   input  logic [WIDTH-1:0]          upd_data_i,
   output logic                      upd_ack_o,
   output logic                      mem_write_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic [WIDTH-1:0]          mem_wdata_o,
   input  logic                      mem_resp_i,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      empty_o,
   output logic                      dbg_state_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = ADDR_W - OFFSET;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   // Handshakes: enqueue transfers on enq_valid_i && enq_ready_o at the clock edge;
   // a memory write completes on the edge where mem_write_o && mem_resp_i.
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [LW-1:0]      line_q [DEPTH];
   logic [WIDTH-1:0]   data_q [DEPTH];
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]        count_q, count_d;

   logic [LW-1:0]      enq_line;
   logic [LW-1:0]      lkp_line;
   logic               lkp_match;
   logic [PW-1:0]      lkp_idx;
   logic               coal_hit;
   logic [PW-1:0]      coal_idx;
   logic               head_busy;
   logic               enq_fire;
   logic               alloc;
   logic               coal_fire;
   logic               pop;
   logic               unused_offset_bits;

   assign enq_line  = enq_addr_i[ADDR_W-1:OFFSET];
   assign lkp_line  = lkp_addr_i[ADDR_W-1:OFFSET];
   assign head_busy = (state_q == BUSY);
   assign unused_offset_bits = ^{enq_addr_i[OFFSET-1:0], lkp_addr_i[OFFSET-1:0]};

   // Scan oldest to youngest so the last match (closest behind wr_ptr) wins.
   always_comb begin
      lkp_match = 1'b0;
      lkp_idx   = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (valid_q[wr_ptr_q - PW'(k)] && (line_q[wr_ptr_q - PW'(k)] == lkp_line)) begin
            lkp_match = 1'b1;
            lkp_idx   = wr_ptr_q - PW'(k);
         end
      end
   end

   assign lkp_hit_o  = lkp_valid_i && lkp_match;
   assign lkp_data_o = lkp_hit_o ? data_q[lkp_idx] : '0;
   assign upd_ack_o  = lkp_hit_o && upd_i && !((lkp_idx == rd_ptr_q) && head_busy);

`ifdef EWB_COALESCE_EN
   // The in-flight head is frozen, so it is never a coalescing target.
   always_comb begin
      coal_hit = 1'b0;
      coal_idx = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (valid_q[wr_ptr_q - PW'(k)] && (line_q[wr_ptr_q - PW'(k)] == enq_line) &&
             !(((wr_ptr_q - PW'(k)) == rd_ptr_q) && head_busy)) begin
            coal_hit = 1'b1;
            coal_idx = wr_ptr_q - PW'(k);
         end
      end
   end
`else
   assign coal_hit = 1'b0;
   assign coal_idx = '0;
`endif

   assign enq_ready_o = (count_q < DEPTH_C) || coal_hit;
   assign enq_fire    = enq_valid_i && enq_ready_o;
   assign coal_fire   = enq_fire && coal_hit;
   assign alloc       = enq_fire && !coal_hit;
   assign pop         = head_busy && mem_resp_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      valid_d  = valid_q;
      count_d  = count_q;
      if (pop) begin
         rd_ptr_d          = rd_ptr_q + 1'b1;
         valid_d[rd_ptr_q] = 1'b0;
      end
      if (alloc) begin
         wr_ptr_d          = wr_ptr_q + 1'b1;
         valid_d[wr_ptr_q] = 1'b1;
      end
      case ({alloc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Drain FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   // Drain FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (count_q != '0) state_d = BUSY;
         BUSY:    if (mem_resp_i)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Drain FSM: outputs
   always_comb begin
      mem_write_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (state_q == BUSY) begin
         mem_write_o = 1'b1;
         mem_addr_o  = ADDR_W'(line_q[rd_ptr_q]) << OFFSET;
         mem_wdata_o = data_q[rd_ptr_q];
      end
   end

   // Entry payload needs no reset; valid bits gate every use. Coalescing data wins over an update.
   always_ff @(posedge clk) begin
      if (upd_ack_o) data_q[lkp_idx] <= upd_data_i;
      if (coal_fire) data_q[coal_idx] <= enq_data_i;
      if (alloc) begin
         line_q[wr_ptr_q] <= enq_line;
         data_q[wr_ptr_q] <= enq_data_i;
      end
   end

   assign count_o     = count_q;
   assign empty_o     = (count_q == '0);
   assign dbg_state_o = head_busy;

endmodule

// File: doc/evict_wb_buffer.md
# evict_wb_buffer

Parametrised eviction write buffer for the L2 cache: it holds dirty lines evicted by the L2, drains them to memory one at a time through a request/response memory port, and services L2 lookups for lines still in flight. It is the next generation of the L2 eviction queue and adds configurable line width, depth and offset, youngest-match lookup priority, a drain state machine with in-flight head protection, and optional write coalescing.

## Interface
- WIDTH, 256: line data width in bits
- DEPTH, 8: entries; power of two, ≥2
- ADDR_W, 32: byte address width
- OFFSET, 5: line offset bits; line address = addr[ADDR_W-1:OFFSET]

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enq_valid_i  in  1  evicted line present
- enq_addr_i  in  ADDR_W  eviction byte address
- enq_data_i  in  WIDTH  eviction data
- enq_ready_o  out  1  buffer accepts a new line
- lkp_valid_i  in  1  lookup request
- lkp_addr_i  in  ADDR_W  lookup byte address
- lkp_hit_o  out  1  line present in buffer
- lkp_data_o  out  WIDTH  data of the youngest matching entry
- upd_i  in  1  overwrite the hit entry with upd_data_i
- upd_data_i  in  WIDTH  replacement line
- upd_ack_o  out  1  update will be applied this cycle
- mem_write_o  out  1  memory write request
- mem_addr_o  out  ADDR_W  head line address, offset bits zero
- mem_wdata_o  out  WIDTH  head line data
- mem_resp_i  in  1  memory write complete
- count_o  out  $clog2(DEPTH)+1  occupied entries
- empty_o  out  1  count_o == 0

## Operation
- Circular storage uses rd_ptr, wr_ptr ($clog2(DEPTH) bits; natural wrap) and count. Per entry: line address (ADDR_W-OFFSET bits), data, and valid.
- Enqueue fires when enq_valid_i && enq_ready_o, with enq_ready_o = (count < DEPTH). Writes the entry at wr_ptr, wr_ptr+1, count+1. Readiness is based on the registered count: a full buffer does not accept a new line in the same cycle the head drains.
- Lookup is combinational over valid entries. Line addresses are compared. On multiple matches, the entry closest to wr_ptr (youngest) wins. lkp_hit_o and lkp_data_o are 0 when lkp_valid_i=0 or on a miss.
- Update: upd_ack_o = lkp_hit_o && upd_i && !(winner == rd_ptr && state == BUSY). If acked, the winner's data is written at the clock edge. An update to the in-flight head is dropped with upd_ack_o=0, and the L2 must reissue it as an enqueue.
- Drain FSM:
  - IDLE: if count≠0, go to BUSY.
  - BUSY: mem_write_o=1, with head address/data presented. On mem_resp_i, pop the head (rd_ptr+1, count-1, valid cleared) and return to IDLE.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- mem_addr_o and mem_wdata_o are stable for the whole BUSY period.
- rst mid-transaction abandons the write: state=IDLE and the buffer is empty. Any later mem_resp_i while IDLE is ignored.

## Timing
- Reset values:
  - enq_ready_o=1
  - lkp_hit_o=0, lkp_data_o=0, upd_ack_o=0
  - mem_write_o=0, mem_addr_o=0, mem_wdata_o=0
  - count_o=0, empty_o=1
  - pointers 0, all valid bits 0, state IDLE
- Enqueue to visible: count_o and the lookup hit appear the cycle after acceptance.
- Enqueue to memory: first mem_write_o is asserted 2 cycles after acceptance into an empty buffer (1 cycle to register, 1 cycle IDLE→BUSY).
- Pop to next request: mem_write_o deasserts for exactly one cycle (the IDLE bubble) between back-to-back drains.
- mem_resp_i is sampled only in BUSY. A response in the first BUSY cycle is legal.
- Lookup and update are combinational with zero latency. A same-cycle enqueue is not visible to the lookup.

## Configuration
- EWB_COALESCE_EN defined:
  - An enqueue whose line address matches a valid entry other than the in-flight head overwrites that entry's data in place. No allocation, count unchanged.
  - enq_ready_o=1 even when full, provided a coalescible match exists.
  - If the only match is the BUSY head, a new entry is allocated.
- EWB_COALESCE_EN undefined: every enqueue allocates. Duplicate lines may coexist and lookup returns the youngest.

## Test plan
- DEPTH=4, OFFSET=5, mem_resp_i held 0: enqueue 0x100, 0x200, 0x300, 0x400 → count_o=4, enq_ready_o=0, 5th enqueue 0x500 ignored; mem_write_o=1 with mem_addr_o=0x100.
- Hold mem_resp_i for 1 cycle in each BUSY period → drains 0x100, 0x200, 0x300, 0x400 in order with one idle cycle between each; pointers wrap; empty_o=1 afterwards; enqueue at 0x600 lands in slot 0.
- Macro off: enqueue 0x100 data A then 0x11F data B; lookup 0x104 → hit, data B; count_o=2.
- Macro on: same stimulus with the head not yet BUSY → count_o=1, data B. With 0x100 already BUSY → count_o=2, memory receives A then B.
- Entries 0x100 (head, BUSY) and 0x200: lookup+update 0x100 → upd_ack_o=0, data unchanged; lookup+update 0x200 with C → upd_ack_o=1, memory later receives C.
- Assert rst while mem_write_o=1 with 3 entries → next cycle count_o=0, mem_write_o=0; a mem_resp_i pulse then causes no pop and no underflow.
